nrzi_rx_decoder: RTL

//   Receive end of the team's NRZI serial line, the counterpart of the NRZI encoder/inverter path.

---
 rtl/nrzi_pkg.sv | 14 +
 rtl/nrzi_byte_fifo.sv | 48 ++++
 rtl/nrzi_rx_decoder.sv | 131 +++++++++++++
 3 files changed

// File: rtl/nrzi_pkg.sv
// Shared NRZI line definitions.
// Used by both the receive decoder and the transmit encoder.
package nrzi_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    ERR  = 2'd2
  } state_t;

  localparam logic IDLE_LEVEL    = 1'b1;
  localparam int   STUFF_LEN_DEF = 6;

endpackage

// File: rtl/nrzi_byte_fifo.sv
// Small synchronous word FIFO for the NRZI receiver.
// A push into a full FIFO succeeds only when a pop happens the same cycle.
module nrzi_byte_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              full,
  output logic              empty
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW:0]       wr_q;
  logic [AW:0]       rd_q;
  logic              do_push;
  logic              do_pop;

  assign empty   = (wr_q == rd_q);
  assign full    = (wr_q[AW] != rd_q[AW]) &&
                   (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rdata   = mem[rd_q[AW-1:0]];

  // Read/write pointers with a wrap bit to tell full from empty.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + (AW+1)'(1);
      if (do_pop)  rd_q <= rd_q + (AW+1)'(1);
    end
  end

  // Storage; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_q[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/nrzi_rx_decoder.sv
// NRZI receive path: decode, remove stuffed bits, deserialise LSB-first.
// Completed words are buffered and offered over valid/ready.
module nrzi_rx_decoder
  import nrzi_pkg::*;
#(
  parameter int STUFF_LEN  = STUFF_LEN_DEF,
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              line_in,
  input  logic              line_vld,
  input  logic              frame_en,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              stuff_err,
  output logic              overflow,
  output logic              trunc
);

  localparam int OW = $clog2(STUFF_LEN + 1);
  localparam int BW = $clog2(DATA_W);

  state_t            state_q, state_d;
  logic              prev_q;
  logic [OW-1:0]     ones_q;
  logic [BW-1:0]     bit_q;
  logic [DATA_W-2:0] sr_q;
  logic              trunc_d;

  logic              accept;
  logic              dbit;
  logic              is_stuff;
  logic              shift;
  logic              stuff_bad;
  logic              word_done;
  logic [DATA_W-1:0] word;
  logic [DATA_W-1:0] fifo_rdata;
  logic              fifo_full;
  logic              fifo_empty;

  assign accept    = line_vld & frame_en & (state_q == RUN);
  assign dbit      = (line_in == prev_q);
  assign is_stuff  = (ones_q == OW'(STUFF_LEN));
  assign shift     = accept & ~is_stuff;
  assign stuff_bad = accept & is_stuff & dbit;
  assign word_done = shift & (bit_q == BW'(DATA_W - 1));
  assign word      = {dbit, sr_q};

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Frame sequencing and truncation detect.
  always_comb begin
    state_d = state_q;
    trunc_d = 1'b0;
    unique case (state_q)
      IDLE: if (frame_en) state_d = RUN;
      RUN: begin
        if (!frame_en) begin
          state_d = IDLE;
          trunc_d = (bit_q != '0);
        end else if (stuff_bad) begin
          state_d = ERR;
        end
      end
      ERR: if (!frame_en) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Decode, destuff and shift datapath.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_q <= IDLE_LEVEL;
      ones_q <= '0;
      bit_q  <= '0;
      sr_q   <= '0;
    end else if (state_d == IDLE) begin
      prev_q <= IDLE_LEVEL;
      ones_q <= '0;
      bit_q  <= '0;
    end else if (accept) begin
      prev_q <= line_in;
      if (is_stuff) begin
        ones_q <= '0;
        if (dbit) bit_q <= '0;
      end else begin
        ones_q <= dbit ? ones_q + OW'(1) : '0;
        sr_q   <= word[DATA_W-1:1];
        bit_q  <= word_done ? '0 : bit_q + BW'(1);
      end
    end
  end

  // One-cycle status pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stuff_err <= 1'b0;
      overflow  <= 1'b0;
      trunc     <= 1'b0;
    end else begin
      stuff_err <= stuff_bad;
      overflow  <= word_done & fifo_full & ~out_ready;
      trunc     <= trunc_d;
    end
  end

  nrzi_byte_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (word_done),
    .pop   (out_ready),
    .wdata (word),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign out_valid = ~fifo_empty;
  assign out_data  = out_valid ? fifo_rdata : '0;

endmodule
